mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-ported, variable-latency backing memory between the fetch stage (instruction reads) and the memory stage (data reads/writes).
- Sits between fetchInstruction/memoryReadWrite and the memory model.
- Serialises requests through a 3-state FSM. Data has priority, with a starvation guard for fetch.
- Drives per-port stall signals so the hazard logic can freeze PC, IF/ID and downstream latches.

Parameters:
DATA_W, 16, data word width
ADDR_W, 16, address width
STARVE_LIMIT, 4, consecutive data grants allowed while fetch waits before fetch is forced (1..7)
TIMEOUT, 64, max cycles in BUSY without mem_done before abort

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous active-high reset
i_req  in  1  fetch read request; held with i_addr until i_done
i_addr  in  ADDR_W  fetch address
i_done  out  1  one-cycle pulse; i_rdata valid this cycle
i_rdata  out  DATA_W  fetched word, registered
i_stall  out  1  i_req & ~i_done
d_req  in  1  data request; held with d_wr/d_addr/d_wdata until d_done
d_wr  in  1  1 = write, 0 = read
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_done  out  1  one-cycle pulse; d_rdata valid this cycle (reads)
d_rdata  out  DATA_W  load data, registered
d_stall  out  1  d_req & ~d_done
mem_req  out  1  request to backing memory, registered
mem_wr  out  1  write strobe, registered
mem_addr  out  ADDR_W  registered address
mem_wdata  out  DATA_W  registered write data
mem_rdata  in  DATA_W  memory read data, valid with mem_done
mem_done  in  1  memory completion, one cycle
err  out  1  sticky timeout error, cleared only by rst

Behaviour:
- Reset (sync, rst=1 at edge):
  - state=IDLE, owner=NONE, all counters 0.
  - All outputs 0, including mem_req, i_rdata/d_rdata, err. This applies mid-transaction; any in-flight memory result is discarded.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - Requests are sampled only here.
  - If d_req and (starve_cnt < STARVE_LIMIT or !i_req): grant data.
  - Else if i_req: grant fetch.
  - On grant: latch owner, addr, wr and wdata into mem_* registers; go to BUSY. mem_req=1 from the next cycle.
  - Fetch grant always has mem_wr=0.
- BUSY:
  - mem_req held at 1, mem_* stable.
  - On mem_done: capture mem_rdata into the owner's rdata register, drop mem_req, go to RESP.
  - Otherwise to_cnt increments.
  - If to_cnt reaches TIMEOUT-1 without mem_done: set err=1, load rdata=0, go to RESP (abort).
- RESP:
  - Owner's done=1 for exactly this cycle; then go to IDLE.
  - A request still held in the following IDLE cycle is treated as a new transaction.
- Latency and throughput:
  - Request in IDLE at cycle 0 → mem_req at cycle 1.
  - If mem_done at cycle k≥1 → done at cycle k+1.
  - Minimum 2-cycle latency; 3 cycles per transaction minimum.
- Starvation guard:
  - starve_cnt (3 bits, saturating at STARVE_LIMIT) increments on each data grant made while i_req=1.
  - Clears on any fetch grant.
  - Unchanged on a data grant with i_req=0.
- rdata registers hold their value until the next completion for that port. The non-owner's rdata is never disturbed.
- Simultaneous d_req and i_req in IDLE with starve_cnt<STARVE_LIMIT: data wins. The fetch port keeps i_stall=1.
- mem_done outside BUSY is ignored.
- A request deasserted while BUSY is a protocol violation. The transaction completes regardless and done still pulses.
- err once set stays 1 until rst. Arbitration continues normally after an abort.

Decomposition:
- Shared package (mem_arb_pkg) holds:
  - state encoding IDLE=2'b00, BUSY=2'b01, RESP=2'b10;
  - owner encoding NONE/IFETCH/DATA;
  - default STARVE_LIMIT and TIMEOUT constants.
- One natural sub-module, arb_timeout_counter: clear/enable/expire counter parameterised by TIMEOUT. It is instanced once in BUSY.

Test Plan:
- Single fetch: i_req=1, i_addr=16'h0010; memory returns mem_done 3 cycles after mem_req with mem_rdata=16'hA5A5 → mem_addr=16'h0010, mem_wr=0, i_done pulses once at cycle 4, i_rdata=16'hA5A5, i_stall 1 through cycle 3 then 0.
- Conflict: i_req and d_req (write, d_addr=16'h0100, d_wdata=16'h1234) both asserted in the same IDLE cycle → data served first with mem_wr=1, mem_wdata=16'h1234; fetch granted only after d_done and RESP.
- Starvation: i_req held high while d_req re-requests immediately after every d_done, STARVE_LIMIT=4 → exactly 4 data grants, then a fetch grant, then starve_cnt=0.
- Timeout: d_req read, mem_done never asserted, TIMEOUT=64 → err=1 at BUSY cycle 64, d_done pulses with d_rdata=0, next i_req is served normally, err stays 1.
- Reset mid-BUSY: rst=1 for one cycle while BUSY → next cycle state IDLE, mem_req=0, err=0, counters 0; a late mem_done is ignored with no done pulse.
- Back-to-back: d_req read held continuously, mem_done same cycle as mem_req → d_done every 3rd cycle, rdata updates each time.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared encodings and default constants for the fetch/data memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        RESP = 2'b10
    } arb_state_e;

    typedef enum logic [1:0] {
        NONE   = 2'b00,
        IFETCH = 2'b01,
        DATA   = 2'b10
    } arb_owner_e;

    localparam int DEF_STARVE_LIMIT = 4;
    localparam int DEF_TIMEOUT      = 64;
    localparam int STARVE_W         = 3;

endpackage

// File: rtl/arb_timeout_counter.sv
// Cycle counter for one memory transaction; o_expire flags the last allowed BUSY cycle.
module arb_timeout_counter
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] r_count;

    // NOTE: sequential state is written with non-blocking assignments so every
    // flop samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expire = (r_count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises fetch and data accesses onto one variable-latency memory port.
// Data has priority; a saturating counter forces a fetch grant after STARVE_LIMIT data grants.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_W       = 16,
    parameter int ADDR_W       = 16,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT,
    parameter int TIMEOUT      = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_done,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_stall,
    input  logic              d_req,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_stall,
    output logic              mem_req,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_done,
    output logic              err
);

    arb_state_e          r_state;
    arb_owner_e          r_owner;
    logic [STARVE_W-1:0] r_starve_cnt;
    logic                r_i_done;
    logic                r_d_done;
    logic [DATA_W-1:0]   r_i_rdata;
    logic [DATA_W-1:0]   r_d_rdata;
    logic                r_mem_req;
    logic                r_mem_wr;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic                r_err;

    logic                w_starved;
    logic                w_grant_data;
    logic                w_expire;
    logic                w_finish;
    logic [DATA_W-1:0]   w_resp_data;

    assign w_starved    = (r_starve_cnt >= STARVE_W'(STARVE_LIMIT));
    assign w_grant_data = d_req && (!w_starved || !i_req);
    assign w_finish     = mem_done || w_expire;
    // An aborted transaction returns zero rather than whatever is on the bus.
    assign w_resp_data  = mem_done ? mem_rdata : '0;

    arb_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (r_state != BUSY),
        .i_enable ((r_state == BUSY) && !mem_done),
        .o_expire (w_expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_owner      <= NONE;
            r_starve_cnt <= '0;
            r_i_done     <= 1'b0;
            r_d_done     <= 1'b0;
            r_i_rdata    <= '0;
            r_d_rdata    <= '0;
            r_mem_req    <= 1'b0;
            r_mem_wr     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_err        <= 1'b0;
        end else begin
            r_i_done <= 1'b0;
            r_d_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_grant_data) begin
                        r_owner     <= DATA;
                        r_mem_req   <= 1'b1;
                        r_mem_wr    <= d_wr;
                        r_mem_addr  <= d_addr;
                        r_mem_wdata <= d_wdata;
                        r_state     <= BUSY;
                        // Data only wins over a waiting fetch below the limit, so this saturates.
                        if (i_req) begin
                            r_starve_cnt <= r_starve_cnt + 1'b1;
                        end
                    end else if (i_req) begin
                        r_owner      <= IFETCH;
                        r_mem_req    <= 1'b1;
                        r_mem_wr     <= 1'b0;
                        r_mem_addr   <= i_addr;
                        r_starve_cnt <= '0;
                        r_state      <= BUSY;
                    end
                end
                BUSY: begin
                    if (w_finish) begin
                        if (r_owner == DATA) begin
                            r_d_rdata <= w_resp_data;
                            r_d_done  <= 1'b1;
                        end else if (r_owner == IFETCH) begin
                            r_i_rdata <= w_resp_data;
                            r_i_done  <= 1'b1;
                        end
                        if (!mem_done) begin
                            r_err <= 1'b1;
                        end
                        r_mem_req <= 1'b0;
                        r_mem_wr  <= 1'b0;
                        r_state   <= RESP;
                    end
                end
                RESP: begin
                    r_owner <= NONE;
                    r_state <= IDLE;
                end
                default: begin
                    r_owner <= NONE;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign i_done    = r_i_done;
    assign i_rdata   = r_i_rdata;
    assign i_stall   = i_req & ~r_i_done;
    assign d_done    = r_d_done;
    assign d_rdata   = r_d_rdata;
    assign d_stall   = d_req & ~r_d_done;
    assign mem_req   = r_mem_req;
    assign mem_wr    = r_mem_wr;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign err       = r_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: vector table plus hand sequences, with a per-port rdata scoreboard.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_req = 1'b0;
    logic [15:0] i_addr = '0;
    logic        i_done;
    logic [15:0] i_rdata;
    logic        i_stall;
    logic        d_req = 1'b0;
    logic        d_wr = 1'b0;
    logic [15:0] d_addr = '0;
    logic [15:0] d_wdata = '0;
    logic        d_done;
    logic [15:0] d_rdata;
    logic        d_stall;
    logic        mem_req;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata = '0;
    logic        mem_done = 1'b0;
    logic        err;

    int checks = 0;
    int errors = 0;

    // Memory model controls: lat = BUSY cycle on which mem_done fires (0 = never).
    int          lat = 1;
    bit          force_done = 1'b0;
    int          busy_cyc = 0;
    logic [15:0] vol_cnt = '0;
    logic [15:0] mem_model [logic [15:0]];

    typedef struct {
        logic [15:0] rdata;
        bit          chk;
    } sb_t;
    sb_t iq[$];
    sb_t dq[$];
    sb_t i_e;
    sb_t d_e;

    typedef struct {
        bit          is_data;
        bit          wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        int          lat;
        logic [15:0] exp_rdata;
    } vec_t;
    vec_t vecs[10];

    mem_port_arbiter #(
        .DATA_W       (16),
        .ADDR_W       (16),
        .STARVE_LIMIT (4),
        .TIMEOUT      (64)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_done    (i_done),
        .i_rdata   (i_rdata),
        .i_stall   (i_stall),
        .d_req     (d_req),
        .d_wr      (d_wr),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_done    (d_done),
        .d_rdata   (d_rdata),
        .d_stall   (d_stall),
        .mem_req   (mem_req),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_done  (mem_done),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic bound_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: no completion within cycle budget (t=%0t)", name, $time);
    endtask

    task automatic push_i(input logic [15:0] rd, input bit chk);
        sb_t e;
        e.rdata = rd;
        e.chk   = chk;
        iq.push_back(e);
    endtask

    task automatic push_d(input logic [15:0] rd, input bit chk);
        sb_t e;
        e.rdata = rd;
        e.chk   = chk;
        dq.push_back(e);
    endtask

    function automatic logic [15:0] model_rd(input logic [15:0] a);
        logic [15:0] v;
        if (a == 16'h0900) begin
            v       = 16'h1000 + vol_cnt;
            vol_cnt = vol_cnt + 16'd1;
        end else if (mem_model.exists(a)) begin
            v = mem_model[a];
        end else begin
            v = ~a;
        end
        return v;
    endfunction

    // Memory responder: drives mem_done/mem_rdata just after each rising edge.
    always begin
        @(posedge clk);
        #1;
        if (mem_req) begin
            busy_cyc++;
            if (lat != 0 && busy_cyc == lat) begin
                mem_done = 1'b1;
                if (mem_wr) begin
                    mem_model[mem_addr] = mem_wdata;
                    mem_rdata = 16'hDEAD;
                end else begin
                    mem_rdata = model_rd(mem_addr);
                end
            end else begin
                mem_done  = 1'b0;
                mem_rdata = 16'h0BAD;
            end
        end else begin
            busy_cyc  = 0;
            mem_done  = force_done;
            mem_rdata = 16'hFFFF;
        end
    end

    // Scoreboard consumer: every done pulse pops the expectation for its port.
    always @(negedge clk) begin
        if (!rst) begin
            if (i_done) begin
                if (iq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL i_sb_underflow: unexpected i_done with i_rdata=%h, expected no pulse", i_rdata);
                end else begin
                    i_e = iq.pop_front();
                    if (i_e.chk) check("i_rdata", 32'(i_rdata), 32'(i_e.rdata));
                end
            end
            if (d_done) begin
                if (dq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL d_sb_underflow: unexpected d_done with d_rdata=%h, expected no pulse", d_rdata);
                end else begin
                    d_e = dq.pop_front();
                    if (d_e.chk) check("d_rdata", 32'(d_rdata), 32'(d_e.rdata));
                end
            end
        end
    end

    // One isolated transaction, raised in an IDLE cycle; returns one cycle after RESP.
    task automatic run_vec(input vec_t v);
        bit seen;
        logic own_done, oth_done, own_stall;
        seen = 1'b0;
        lat  = v.lat;
        if (v.is_data) begin
            push_d(v.exp_rdata, !v.wr);
            d_wr    = v.wr;
            d_addr  = v.addr;
            d_wdata = v.wdata;
            d_req   = 1'b1;
        end else begin
            push_i(v.exp_rdata, 1'b1);
            i_addr = v.addr;
            i_req  = 1'b1;
        end
        for (int n = 1; n <= v.lat + 10 && !seen; n++) begin
            @(negedge clk);
            own_done  = v.is_data ? d_done : i_done;
            oth_done  = v.is_data ? i_done : d_done;
            own_stall = v.is_data ? d_stall : i_stall;
            if (n == 1) begin
                check("vec_mem_req", 32'(mem_req), 32'd1);
                check("vec_mem_addr", 32'(mem_addr), 32'(v.addr));
                check("vec_mem_wr", 32'(mem_wr), 32'(v.is_data & v.wr));
                if (v.is_data && v.wr) check("vec_mem_wdata", 32'(mem_wdata), 32'(v.wdata));
                check("vec_stall_busy", 32'(own_stall), 32'd1);
            end
            if (own_done) begin
                seen = 1'b1;
                check("vec_latency", 32'(n), 32'(v.lat + 1));
                check("vec_stall_done", 32'(own_stall), 32'd0);
                check("vec_other_done", 32'(oth_done), 32'd0);
                i_req = 1'b0;
                d_req = 1'b0;
            end
        end
        if (!seen) begin
            bound_fail("vec_done");
            i_req = 1'b0;
            d_req = 1'b0;
        end
        @(negedge clk);
    endtask

    initial begin
        int dn, in_n, dcnt, tcnt;
        int times[3];
        bit seen;

        vecs[0] = '{1'b1, 1'b1, 16'h0010, 16'hA5A5, 2, 16'h0000};
        vecs[1] = '{1'b0, 1'b0, 16'h0010, 16'h0000, 3, 16'hA5A5};
        vecs[2] = '{1'b1, 1'b0, 16'h0010, 16'h0000, 1, 16'hA5A5};
        vecs[3] = '{1'b1, 1'b1, 16'h0100, 16'h1234, 5, 16'h0000};
        vecs[4] = '{1'b1, 1'b0, 16'h0100, 16'h0000, 4, 16'h1234};
        vecs[5] = '{1'b0, 1'b0, 16'h0100, 16'h0000, 1, 16'h1234};
        vecs[6] = '{1'b0, 1'b0, 16'h0200, 16'h0000, 2, 16'hFDFF};
        vecs[7] = '{1'b1, 1'b1, 16'hFFFF, 16'hBEEF, 1, 16'h0000};
        vecs[8] = '{1'b0, 1'b0, 16'hFFFF, 16'h0000, 6, 16'hBEEF};
        vecs[9] = '{1'b1, 1'b0, 16'h0000, 16'h0000, 2, 16'hFFFF};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_i_done", 32'(i_done), 32'd0);
        check("rst_d_done", 32'(d_done), 32'd0);
        check("rst_i_rdata", 32'(i_rdata), 32'd0);
        check("rst_d_rdata", 32'(d_rdata), 32'd0);
        check("rst_state", 32'(dut.r_state), 32'(IDLE));
        rst = 1'b0;
        @(negedge clk);

        for (int k = 0; k < 10; k++) run_vec(vecs[k]);

        // Conflict: data write and fetch raised together; data first, fetch after RESP.
        lat = 2;
        push_d(16'h0000, 1'b0);
        push_i(16'hFAFF, 1'b1);
        d_wr = 1'b1; d_addr = 16'h0100; d_wdata = 16'h1234; d_req = 1'b1;
        i_addr = 16'h0500; i_req = 1'b1;
        dn = 0; in_n = 0;
        for (int n = 1; n <= 30 && in_n == 0; n++) begin
            @(negedge clk);
            if (n == 1) begin
                check("cf_mem_wr", 32'(mem_wr), 32'd1);
                check("cf_mem_addr", 32'(mem_addr), 32'h0100);
                check("cf_mem_wdata", 32'(mem_wdata), 32'h1234);
                check("cf_i_stall", 32'(i_stall), 32'd1);
            end
            if (dn != 0 && n == dn + 2) begin
                check("cf_fetch_addr", 32'(mem_addr), 32'h0500);
                check("cf_fetch_wr", 32'(mem_wr), 32'd0);
            end
            if (d_done) begin
                dn = n;
                check("cf_i_done_early", 32'(i_done), 32'd0);
                d_req = 1'b0;
            end
            if (i_done) begin
                in_n = n;
                i_req = 1'b0;
            end
        end
        if (in_n == 0) bound_fail("cf_fetch_done");
        else check("cf_fetch_latency", 32'(in_n - dn), 32'd4);
        i_req = 1'b0; d_req = 1'b0; d_wr = 1'b0;
        @(negedge clk);

        // Starvation: fetch held, data re-requests every time; fetch wins after 4 data grants.
        lat = 1;
        for (int k = 0; k < 4; k++) push_d(16'hFCFF, 1'b1);
        push_i(16'hFBFF, 1'b1);
        i_addr = 16'h0400; i_req = 1'b1;
        d_wr = 1'b0; d_addr = 16'h0300; d_req = 1'b1;
        dcnt = 0; seen = 1'b0;
        for (int n = 1; n <= 60 && !seen; n++) begin
            @(negedge clk);
            if (d_done) dcnt++;
            if (i_done) begin
                seen = 1'b1;
                check("starve_data_grants", 32'(dcnt), 32'd4);
                check("starve_cnt_clear", 32'(dut.r_starve_cnt), 32'd0);
                i_req = 1'b0;
                d_req = 1'b0;
            end
        end
        if (!seen) bound_fail("starve_fetch");
        i_req = 1'b0; d_req = 1'b0;
        @(negedge clk);

        // Back-to-back: held data read, mem_done with mem_req -> d_done every 3rd cycle.
        lat = 1; vol_cnt = '0;
        for (int k = 0; k < 3; k++) push_d(16'h1000 + 16'(k), 1'b1);
        d_wr = 1'b0; d_addr = 16'h0900; d_req = 1'b1;
        tcnt = 0;
        for (int n = 1; n <= 20 && tcnt < 3; n++) begin
            @(negedge clk);
            if (d_done) begin
                times[tcnt] = n;
                tcnt++;
                if (tcnt == 3) d_req = 1'b0;
            end
        end
        d_req = 1'b0;
        if (tcnt < 3) bound_fail("b2b_done");
        else begin
            check("b2b_first", 32'(times[0]), 32'd2);
            check("b2b_gap1", 32'(times[1] - times[0]), 32'd3);
            check("b2b_gap2", 32'(times[2] - times[1]), 32'd3);
        end
        @(negedge clk);

        // Timeout: memory never answers; abort after 64 BUSY cycles with zero data.
        lat = 0;
        push_d(16'h0000, 1'b1);
        d_wr = 1'b0; d_addr = 16'h0600; d_req = 1'b1;
        seen = 1'b0;
        for (int n = 1; n <= 80 && !seen; n++) begin
            @(negedge clk);
            if (n == 64) check("to_err_before", 32'(err), 32'd0);
            if (d_done) begin
                seen = 1'b1;
                check("to_done_cycle", 32'(n), 32'd65);
                check("to_err_set", 32'(err), 32'd1);
                d_req = 1'b0;
            end
        end
        if (!seen) bound_fail("to_done");
        d_req = 1'b0;
        @(negedge clk);
        run_vec('{1'b0, 1'b0, 16'h0700, 16'h0000, 1, 16'hF8FF});
        check("to_err_sticky", 32'(err), 32'd1);

        // Reset while BUSY, then a stray mem_done that must be ignored.
        lat = 0;
        d_wr = 1'b0; d_addr = 16'h0800; d_req = 1'b1;
        repeat (3) @(negedge clk);
        check("rb_busy", 32'(mem_req), 32'd1);
        rst = 1'b1; d_req = 1'b0; force_done = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rb_mem_req", 32'(mem_req), 32'd0);
        check("rb_err", 32'(err), 32'd0);
        check("rb_state", 32'(dut.r_state), 32'(IDLE));
        check("rb_to_cnt", 32'(dut.u_timeout.r_count), 32'd0);
        check("rb_starve", 32'(dut.r_starve_cnt), 32'd0);
        check("rb_d_rdata", 32'(d_rdata), 32'd0);
        @(negedge clk);
        force_done = 1'b0;
        check("rb_late_d_done", 32'(d_done), 32'd0);
        check("rb_late_i_done", 32'(i_done), 32'd0);
        check("rb_late_d_rdata", 32'(d_rdata), 32'd0);
        check("rb_late_state", 32'(dut.r_state), 32'(IDLE));
        repeat (2) @(negedge clk);

        check("sb_i_empty", 32'(iq.size()), 32'd0);
        check("sb_d_empty", 32'(dq.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
